// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants and types for the seg_scan multiplexed
// seven-segment display driver. Segment patterns are {g,f,e,d,c,b,a},
// active-low.
package seg_scan_pkg;

  // Each digit dwell is divided into this many brightness slices.
  localparam int BRIGHT_SLICES = 8;

  // All segments dark.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Hex glyphs, indexed by nibble value (index 15 listed first).
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Pending write buffer occupancy.
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: write port of the display driver. The master offers a full
// frame of digits (nibbles, decimal points, enables) with a valid/ready
// handshake; the slave is the display driver.
interface seg_scan_if #(
  parameter int DIGITS = 8
);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [4*DIGITS-1:0]   wr_data;
  logic [DIGITS-1:0]     wr_dp;
  logic [DIGITS-1:0]     wr_mask;

  modport master (
    output wr_valid,
    output wr_data,
    output wr_dp,
    output wr_mask,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_dp,
    input  wr_mask,
    output wr_ready
  );

endinterface

// File: rtl/seg_hex_dec.sv
// seg_hex_dec: combinational hex nibble to active-low seven-segment glyph.
module seg_hex_dec
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup of the glyph for the nibble.
  always_comb begin
    seg = HEX_TABLE[hex];
  end

endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed seven-segment display driver with a
// double-buffered write port (new data only lands on a frame boundary, so a
// frame never mixes old and new digits), per-dwell PWM brightness and a
// ghosting guard cycle at the start of every dwell.
// Optional feature: define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DIGIT_HZ = 1000,
  parameter int DIGITS   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_if.slave         wr,
  input  logic [2:0]        bright,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame_tick
);

  localparam int DWELL     = CLK_FREQ / DIGIT_HZ;
  localparam int SLICE_LEN = DWELL / BRIGHT_SLICES;
  localparam int SUB_W     = (SLICE_LEN > 1) ? $clog2(SLICE_LEN) : 1;
  localparam int DIG_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(SLICE_LEN - 1);
  localparam logic [2:0]       SLICE_LAST = 3'(BRIGHT_SLICES - 1);
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(DIGITS - 1);

  // Prescaler split as (slice, cycle within slice) so PWM needs no divider.
  logic [SUB_W-1:0] sub_cnt;
  logic [2:0]       slice_cnt;
  logic [DIG_W-1:0] dig_idx;
  logic [2:0]       bright_q;
  logic             after_guard;

  logic dwell_start;
  logic dwell_end;
  logic frame_wrap;

  buf_state_t buf_state;
  buf_state_t buf_next;
  logic       accept;
  logic       commit;
  logic       ready_q;

  logic [DIGITS-1:0][3:0] pend_data;
  logic [DIGITS-1:0]      pend_dp;
  logic [DIGITS-1:0]      pend_mask;
  logic [DIGITS-1:0][3:0] act_data;
  logic [DIGITS-1:0]      act_dp;
  logic [DIGITS-1:0]      act_mask;

  logic [3:0]        cur_nib;
  logic [6:0]        dec_seg;
  logic              digit_en;
  logic              lit;
  logic [DIGITS-1:0] an_next;
  logic [6:0]        seg_next;
  logic              dp_next;

  assign dwell_start = (slice_cnt == 3'd0) && (sub_cnt == '0);
  assign dwell_end   = (slice_cnt == SLICE_LAST) && (sub_cnt == SUB_LAST);
  assign frame_wrap  = dwell_end && (dig_idx == DIG_LAST);
  assign frame_tick  = frame_wrap;
  assign wr.wr_ready = ready_q;

  // Dwell prescaler and digit index; the digit advances when a dwell ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt   <= '0;
      slice_cnt <= '0;
      dig_idx   <= '0;
    end else if (dwell_end) begin
      sub_cnt   <= '0;
      slice_cnt <= '0;
      dig_idx   <= (dig_idx == DIG_LAST) ? '0 : dig_idx + DIG_W'(1);
    end else if (sub_cnt == SUB_LAST) begin
      sub_cnt   <= '0;
      slice_cnt <= slice_cnt + 3'd1;
    end else begin
      sub_cnt   <= sub_cnt + SUB_W'(1);
    end
  end

  // Brightness is held for a whole dwell; after_guard marks the cycle right
  // after the guard so even a one-cycle slice 0 never leaves a digit dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_q    <= '0;
      after_guard <= 1'b0;
    end else begin
      after_guard <= dwell_start;
      if (dwell_start) begin
        bright_q <= bright;
      end
    end
  end

  // Pending buffer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_state <= BUF_EMPTY;
    end else begin
      buf_state <= buf_next;
    end
  end

  // Buffer fills on an accepted write and drains only on a frame boundary.
  always_comb begin
    buf_next = buf_state;
    accept   = 1'b0;
    commit   = 1'b0;
    case (buf_state)
      BUF_EMPTY: begin
        if (wr.wr_valid && ready_q) begin
          accept   = 1'b1;
          buf_next = BUF_FULL;
        end
      end
      BUF_FULL: begin
        if (frame_wrap) begin
          commit   = 1'b1;
          buf_next = BUF_EMPTY;
        end
      end
      default: buf_next = BUF_EMPTY;
    endcase
  end

  // Ready is registered so it stays low during reset and rises one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (buf_next == BUF_EMPTY);
    end
  end

  // Capture accepted writes, then promote them to the displayed registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data <= '0;
      pend_dp   <= '0;
      pend_mask <= '0;
      act_data  <= '0;
      act_dp    <= '0;
      act_mask  <= '0;
    end else begin
      if (accept) begin
        pend_data <= wr.wr_data;
        pend_dp   <= wr.wr_dp;
        pend_mask <= wr.wr_mask;
      end
      if (commit) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
        act_mask <= pend_mask;
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  logic [DIGITS-1:0] lzb_blank;
  logic              zeros_above;

  // Walk down from the top digit; a zero stays dark while everything above is dark.
  always_comb begin
    lzb_blank   = '0;
    zeros_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (zeros_above && (act_data[i] == 4'd0) && !act_dp[i]) begin
        lzb_blank[i] = 1'b1;
      end
      zeros_above = zeros_above && ((act_data[i] == 4'd0) || !act_mask[i]);
    end
  end

  assign digit_en = act_mask[dig_idx] && !lzb_blank[dig_idx];
`else
  assign digit_en = act_mask[dig_idx];
`endif

  assign cur_nib = act_data[dig_idx];

  seg_hex_dec u_hex_dec (
    .hex (cur_nib),
    .seg (dec_seg)
  );

  // Decide what the current prescaler/digit state should put on the pins.
  always_comb begin
    lit      = digit_en && !dwell_start && ((slice_cnt <= bright_q) || after_guard);
    an_next  = '1;
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if (lit) begin
      an_next[dig_idx] = 1'b0;
    end
    if (digit_en) begin
      seg_next = dec_seg;
      dp_next  = !act_dp[dig_idx];
    end
  end

  // Register the pins so they change cleanly on one clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: table-driven self-checking bench for seg_scan with
// DWELL = 8 cycles and 4 digits. Expected glyphs and anode patterns are
// hand-written; LZB expectations switch on SEG_SCAN_LZB_EN.
module tb_seg_scan;

  localparam int DIGITS = 4;

`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110;
  localparam logic [6:0] SD = 7'b0100001;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SF = 7'b0001110;

  typedef struct {
    string            name;
    logic [15:0]      data;
    logic [3:0]       dpin;
    logic [3:0]       mask;
    logic [2:0]       brt;
    logic [3:0][6:0]  exp_seg;
    logic [3:0]       exp_dp;
    logic [3:0][7:0]  exp_low;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic [2:0]        bright;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;
  logic              dp;
  logic              frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs[7];
  vec_t vx, vy, vblank;

  logic [3:0] cap_an  [32];
  logic [6:0] cap_seg [32];
  logic       cap_dp  [32];

  seg_scan_if #(.DIGITS(DIGITS)) wr_if ();

  seg_scan #(
    .CLK_FREQ (8000),
    .DIGIT_HZ (1000),
    .DIGITS   (DIGITS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (wr_if.slave),
    .bright     (bright),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input string name, input logic [15:0] data,
                                 input logic [3:0] dpin, input logic [3:0] mask,
                                 input logic [2:0] brt, input logic [27:0] eseg,
                                 input logic [3:0] edp, input logic [31:0] elow);
    vec_t v;
    v.name    = name;
    v.data    = data;
    v.dpin    = dpin;
    v.mask    = mask;
    v.brt     = brt;
    v.exp_seg = eseg;
    v.exp_dp  = edp;
    v.exp_low = elow;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Offer a write and hold it until the DUT takes it.
  task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dpin,
                               input logic [3:0] mask);
    int guard;
    wr_if.wr_data  = data;
    wr_if.wr_dp    = dpin;
    wr_if.wr_mask  = mask;
    wr_if.wr_valid = 1'b1;
    guard = 0;
    while (wr_if.wr_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("write ready seen", {31'd0, wr_if.wr_ready}, 32'd1);
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic waitFrame(input string tag);
    int guard;
    guard = 0;
    while (frame_tick !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, " frame_tick seen"}, {31'd0, frame_tick}, 32'd1);
  endtask

  // Called two negedges after frame_tick; sample g matches dwell state g.
  task automatic captureFrame();
    for (int g = 0; g < 32; g++) begin
      cap_an[g]  = an;
      cap_seg[g] = seg;
      cap_dp[g]  = dp;
      if (g < 31) @(negedge clk);
    end
  endtask

  task automatic checkFrame(input vec_t v);
    logic [7:0] lowpat;
    logic [3:0] stray;
    for (int d = 0; d < DIGITS; d++) begin
      lowpat = '0;
      stray  = '0;
      for (int p = 0; p < 8; p++) begin
        lowpat[p] = ~cap_an[d*8+p][d];
        stray     = stray | (~cap_an[d*8+p] & ~(4'b0001 << d));
      end
      checkOutput($sformatf("%s seg d%0d", v.name, d), {25'd0, cap_seg[d*8+1]}, {25'd0, v.exp_seg[d]});
      checkOutput($sformatf("%s dp d%0d", v.name, d), {31'd0, cap_dp[d*8+1]}, {31'd0, v.exp_dp[d]});
      checkOutput($sformatf("%s an low cycles d%0d", v.name, d), {24'd0, lowpat}, {24'd0, v.exp_low[d]});
      checkOutput($sformatf("%s stray anodes d%0d", v.name, d), {28'd0, stray}, 32'd0);
    end
  endtask

  // Main sequence.
  initial begin
    int cnt;

    vecs[0] = mkVec("v1_08AF_b7", 16'h08AF, 4'b0000, 4'b1111, 3'd7,
                    {LZB ? BL : S0, S8, SA, SF}, 4'b1111,
                    {LZB ? 8'h00 : 8'hFE, 8'hFE, 8'hFE, 8'hFE});
    vecs[1] = mkVec("v2_08AF_b0_dp", 16'h08AF, 4'b0101, 4'b1111, 3'd0,
                    {LZB ? BL : S0, S8, SA, SF}, 4'b1010,
                    {LZB ? 8'h00 : 8'h02, 8'h02, 8'h02, 8'h02});
    vecs[2] = mkVec("v3_08AF_b3", 16'h08AF, 4'b0000, 4'b1111, 3'd3,
                    {LZB ? BL : S0, S8, SA, SF}, 4'b1111,
                    {LZB ? 8'h00 : 8'h0E, 8'h0E, 8'h0E, 8'h0E});
    vecs[3] = mkVec("v4_1234_mask", 16'h1234, 4'b0001, 4'b1010, 3'd7,
                    {S1, BL, S3, BL}, 4'b1111,
                    {8'hFE, 8'h00, 8'hFE, 8'h00});
    vecs[4] = mkVec("v5_0050", 16'h0050, 4'b0000, 4'b1111, 3'd7,
                    {LZB ? BL : S0, LZB ? BL : S0, S5, S0}, 4'b1111,
                    {LZB ? 8'h00 : 8'hFE, LZB ? 8'h00 : 8'hFE, 8'hFE, 8'hFE});
    vecs[5] = mkVec("v6_00C0_dp2", 16'h00C0, 4'b0100, 4'b1111, 3'd5,
                    {LZB ? BL : S0, S0, SC, S0}, 4'b1011,
                    {LZB ? 8'h00 : 8'h3E, 8'h3E, 8'h3E, 8'h3E});
    vecs[6] = mkVec("v7_7030_m0111", 16'h7030, 4'b0000, 4'b0111, 3'd7,
                    {BL, LZB ? BL : S0, S3, S0}, 4'b1111,
                    {8'h00, LZB ? 8'h00 : 8'hFE, 8'hFE, 8'hFE});
    vx     = mkVec("seq_x_4321", 16'h4321, 4'b0000, 4'b1111, 3'd7,
                   {S4, S3, S2, S1}, 4'b1111, {8'hFE, 8'hFE, 8'hFE, 8'hFE});
    vy     = mkVec("seq_y_BD9E", 16'hBD9E, 4'b0000, 4'b1111, 3'd7,
                   {SB, SD, S9, SE}, 4'b1111, {8'hFE, 8'hFE, 8'hFE, 8'hFE});
    vblank = mkVec("after_reset", 16'h0000, 4'b0000, 4'b0000, 3'd7,
                   {BL, BL, BL, BL}, 4'b1111, 32'h0);

    rst_n          = 1'b1;
    bright         = 3'd7;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;
    wr_if.wr_dp    = '0;
    wr_if.wr_mask  = '0;
    #1 rst_n = 1'b0;

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    checkOutput("reset an", {28'd0, an}, 32'hF);
    checkOutput("reset seg", {25'd0, seg}, {25'd0, BL});
    checkOutput("reset dp", {31'd0, dp}, 32'd1);
    checkOutput("reset wr_ready", {31'd0, wr_if.wr_ready}, 32'd0);
    checkOutput("reset frame_tick", {31'd0, frame_tick}, 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release wr_ready", {31'd0, wr_if.wr_ready}, 32'd1);
    checkOutput("release an", {28'd0, an}, 32'hF);
    checkOutput("release seg", {25'd0, seg}, {25'd0, BL});
    checkOutput("release dp", {31'd0, dp}, 32'd1);

    // Frame period.
    waitFrame("first");
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (frame_tick !== 1'b1 && cnt < 100);
    checkOutput("frame period", cnt, 32'd32);

    // Table-driven display vectors.
    for (int i = 0; i < 7; i++) begin
      bright = vecs[i].brt;
      applyStimulus(vecs[i].data, vecs[i].dpin, vecs[i].mask);
      checkOutput({vecs[i].name, " ready drops"}, {31'd0, wr_if.wr_ready}, 32'd0);
      waitFrame(vecs[i].name);
      @(negedge clk);
      checkOutput({vecs[i].name, " ready after commit"}, {31'd0, wr_if.wr_ready}, 32'd1);
      @(negedge clk);
      captureFrame();
      checkFrame(vecs[i]);
    end

    // Second write while busy is refused; write on the commit cycle lands one frame later.
    bright = 3'd7;
    waitFrame("seq sync");
    applyStimulus(vx.data, vx.dpin, vx.mask);
    wr_if.wr_data  = 16'h9999;
    wr_if.wr_dp    = 4'b1111;
    wr_if.wr_mask  = 4'b1111;
    wr_if.wr_valid = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("busy wr_ready", {31'd0, wr_if.wr_ready}, 32'd0);
    wr_if.wr_valid = 1'b0;
    waitFrame("seq commit x");
    checkOutput("commit cycle wr_ready", {31'd0, wr_if.wr_ready}, 32'd0);
    wr_if.wr_data  = vy.data;
    wr_if.wr_dp    = vy.dpin;
    wr_if.wr_mask  = vy.mask;
    wr_if.wr_valid = 1'b1;
    @(negedge clk);
    checkOutput("post commit wr_ready", {31'd0, wr_if.wr_ready}, 32'd1);
    @(negedge clk);
    checkOutput("y accepted wr_ready", {31'd0, wr_if.wr_ready}, 32'd0);
    wr_if.wr_valid = 1'b0;
    captureFrame();
    checkFrame(vx);
    waitFrame("seq commit y");
    @(negedge clk);
    @(negedge clk);
    captureFrame();
    checkFrame(vy);

    // Reset mid-dwell with a write pending.
    applyStimulus(16'h8888, 4'b1111, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pending wr_ready", {31'd0, wr_if.wr_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid reset an", {28'd0, an}, 32'hF);
    checkOutput("mid reset seg", {25'd0, seg}, {25'd0, BL});
    checkOutput("mid reset dp", {31'd0, dp}, 32'd1);
    checkOutput("mid reset wr_ready", {31'd0, wr_if.wr_ready}, 32'd0);
    checkOutput("mid reset frame_tick", {31'd0, frame_tick}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("re-release wr_ready", {31'd0, wr_if.wr_ready}, 32'd1);
    waitFrame("after reset");
    @(negedge clk);
    @(negedge clk);
    captureFrame();
    checkFrame(vblank);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
